inst_align_buffer: RTL and testbench



---
 rtl/inst_align_buffer.sv | 131 +++++++++++++
 tb/tb_inst_align_buffer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_align_buffer.sv
// rtl/inst_align_buffer.sv - fetch-side instruction alignment buffer feeding decode
// Define RVC_EN for 16-bit compressed support; otherwise every instruction is a 32-bit word.
module inst_align_buffer #(
  parameter logic [31:0] RESET_PC = 32'h6000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_compressed
);

  typedef enum logic [1:0] {F_IDLE, F_WAIT, F_DROP} fstate_t;

  fstate_t     state_q, state_d;
  logic [15:0] par_q [4];
  logic [15:0] par_d [4];
  logic [1:0]  head_q, head_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] faddr_q, faddr_d;
`ifdef RVC_EN
  logic        skip_q, skip_d;
`endif

  logic [15:0] hd0, hd1;
  logic        is_c, skip_low, fire, resp_ok;
  logic [2:0]  pop_n, push_n, cnt_after;
  logic [1:0]  tail;

  always_comb begin
    hd0 = par_q[head_q];
    hd1 = par_q[head_q + 2'd1];
`ifdef RVC_EN
    is_c     = hd0[1:0] != 2'b11;
    skip_low = skip_q;
`else
    is_c     = 1'b0;
    skip_low = 1'b0;
`endif
    o_valid      = (cnt_q >= 3'd1 && is_c) || (cnt_q >= 3'd2);
    o_compressed = o_valid & is_c;
    o_inst       = '0;
    if (o_valid) o_inst = is_c ? {16'h0000, hd0} : {hd1, hd0};
    o_pc      = pc_q;
    imem_addr = faddr_q;

    // A handshake during redirect is killed downstream, so it must not pop.
    fire      = o_valid & i_ready & ~redirect;
    pop_n     = fire ? (is_c ? 3'd1 : 3'd2) : 3'd0;
    resp_ok   = (state_q == F_WAIT) & imem_resp & ~redirect;
    push_n    = resp_ok ? (skip_low ? 3'd1 : 3'd2) : 3'd0;
    cnt_after = cnt_q - pop_n + push_n;
    tail      = head_q + cnt_q[1:0];
    imem_req  = rst_n & ~redirect & ((state_q == F_IDLE) | resp_ok) & (cnt_after <= 3'd2);

    state_d = state_q;
    head_d  = head_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    faddr_d = faddr_q;
    par_d   = par_q;
`ifdef RVC_EN
    skip_d  = skip_q;
`endif
    if (redirect) begin
      cnt_d   = 3'd0;
      pc_d    = redirect_pc;
      faddr_d = {redirect_pc[31:2], 2'b00};
`ifdef RVC_EN
      skip_d  = redirect_pc[1];
`endif
      // A response landing in this cycle is the stale one, so nothing is left to drop.
      if (state_q != F_IDLE) state_d = imem_resp ? F_IDLE : F_DROP;
    end else begin
      head_d = head_q + pop_n[1:0];
      cnt_d  = cnt_after;
      pc_d   = pc_q + {28'd0, pop_n, 1'b0};
      if (resp_ok) begin
        if (skip_low) begin
          par_d[tail] = imem_rdata[31:16];
        end else begin
          par_d[tail]         = imem_rdata[15:0];
          par_d[tail + 2'd1]  = imem_rdata[31:16];
        end
`ifdef RVC_EN
        skip_d = 1'b0;
`endif
      end
      if (state_q != F_IDLE && imem_resp) state_d = F_IDLE;
      if (imem_req) begin
        state_d = F_WAIT;
        faddr_d = faddr_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= F_IDLE;
      head_q  <= '0;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      faddr_q <= RESET_PC;
      for (int i = 0; i < 4; i++) par_q[i] <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      faddr_q <= faddr_d;
      par_q   <= par_d;
    end
  end

`ifdef RVC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) skip_q <= 1'b0;
    else        skip_q <= skip_d;
  end
`endif

endmodule

// File: tb/tb_inst_align_buffer.sv
// tb/tb_inst_align_buffer.sv - scoreboard bench for inst_align_buffer
// Latency-programmable memory model; monitor compares every accepted instruction.
module tb_inst_align_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_resp = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        o_compressed;

  inst_align_buffer #(.RESET_PC(32'h6000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_inst(o_inst), .o_pc(o_pc), .o_compressed(o_compressed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        c;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] req_log[$];
  logic [31:0] mem [logic [31:0]];
  int          n_total = 0;
  int          n_pass = 0;
  int          lat = 1;
  int          wcnt = 0;
  logic        pend = 1'b0;
  logic [31:0] paddr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0000_0013;
  endfunction

  task automatic expect_i(input logic [31:0] inst, input logic [31:0] pc, input logic c);
    exp_t e;
    e.inst = inst;
    e.pc   = pc;
    e.c    = c;
    exp_q.push_back(e);
  endtask

  task automatic chk_log(input string name, input int idx, input logic [31:0] exp);
    logic [31:0] a;
    a = (idx < req_log.size()) ? req_log[idx] : 32'hxxxx_xxxx;
    chk(name, a, exp);
  endtask

  task automatic drain(input string name);
    i_ready = 1'b1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    i_ready = 1'b0;
    chk(name, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic settle();
    i_ready = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    req_log.delete();
    @(negedge clk);
    redirect = 1'b0;
  endtask

  // Memory: answers each request after lat cycles
  always @(negedge clk) begin
    imem_resp = 1'b0;
    if (pend) begin
      if (wcnt <= 1) begin
        imem_resp  = 1'b1;
        imem_rdata = mem_word(paddr);
        pend       = 1'b0;
      end else begin
        wcnt = wcnt - 1;
      end
    end
    #4;
    if (!rst_n) begin
      pend = 1'b0;
    end else if (imem_req) begin
      chk("one_outstanding", {31'd0, pend}, 32'd0);
      req_log.push_back(imem_addr);
      pend  = 1'b1;
      wcnt  = lat;
      paddr = imem_addr;
    end
  end

  // Monitor: every accepted instruction must match the scoreboard head
  always @(negedge clk) begin
    #4;
    if (rst_n && o_valid && i_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", {31'd0, o_valid}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_inst", o_inst, mon_e.inst);
        chk("out_pc", o_pc, mon_e.pc);
        chk("out_compressed", {31'd0, o_compressed}, {31'd0, mon_e.c});
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_inst", o_inst, 32'd0);
    chk("rst_pc", o_pc, 32'h6000_0000);
    chk("rst_compressed", {31'd0, o_compressed}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h6000_0000);

    // Sequential 32-bit stream from reset with single-cycle memory
    for (int i = 0; i < 4; i++) expect_i(32'h0000_0013, 32'h6000_0000 + 32'(4 * i), 1'b0);
    rst_n = 1'b1;
    drain("seq_drain");
    for (int i = 0; i < 4; i++) chk_log("seq_addr", i, 32'h6000_0000 + 32'(4 * i));

    // Fetch address and PC wrap
    settle();
    lat = 1;
    expect_i(32'h0000_0013, 32'hFFFF_FFF8, 1'b0);
    expect_i(32'h0000_0013, 32'hFFFF_FFFC, 1'b0);
    expect_i(32'h0000_0013, 32'h0000_0000, 1'b0);
    do_redirect(32'hFFFF_FFF8);
    drain("wrap_drain");
    chk_log("wrap_addr0", 0, 32'hFFFF_FFF8);
    chk_log("wrap_addr1", 1, 32'hFFFF_FFFC);
    chk_log("wrap_addr2", 2, 32'h0000_0000);

    // Redirect while waiting; the stale response arrives two cycles later
    settle();
    lat = 3;
    mem[32'h6000_2000] = 32'h1111_1113;
    mem[32'h6000_3000] = 32'h2222_2223;
    expect_i(32'h2222_2223, 32'h6000_3000, 1'b0);
    expect_i(32'h0000_0013, 32'h6000_3004, 1'b0);
    do_redirect(32'h6000_2000);
    @(negedge clk);
    do_redirect(32'h6000_3000);
    chk("drop_valid_n1", {31'd0, o_valid}, 32'd0);
    @(negedge clk);
    chk("drop_valid_n2", {31'd0, o_valid}, 32'd0);
    drain("drop_drain");
    chk_log("drop_addr", 0, 32'h6000_3000);

    // Downstream stall: buffer fills with two words and holds its head
    settle();
    lat = 1;
    do_redirect(32'h6000_4000);
    repeat (12) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", {31'd0, o_valid}, 32'd1);
      chk("stall_inst", o_inst, 32'h0000_0013);
      chk("stall_pc", o_pc, 32'h6000_4000);
      @(negedge clk);
    end
    chk("stall_nreq", req_log.size(), 32'd2);
    for (int i = 0; i < 3; i++) expect_i(32'h0000_0013, 32'h6000_4000 + 32'(4 * i), 1'b0);
    drain("stall_drain");

`ifdef RVC_EN
    // c.li followed by a 32-bit instruction split across two words
    settle();
    lat = 8;
    mem[32'h6000_1000] = 32'h0513_4501;
    mem[32'h6000_1004] = 32'h0000_0000;
    expect_i(32'h0000_4501, 32'h6000_1000, 1'b1);
    expect_i(32'h0000_0513, 32'h6000_1002, 1'b0);
    expect_i(32'h0000_0000, 32'h6000_1006, 1'b1);
    expect_i(32'h0000_0013, 32'h6000_1008, 1'b0);
    do_redirect(32'h6000_1000);
    for (int i = 0; i < 40 && !o_valid; i++) @(negedge clk);
    chk("split_first_valid", {31'd0, o_valid}, 32'd1);
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    chk("split_hold_valid", {31'd0, o_valid}, 32'd0);
    chk("split_hold_pc", o_pc, 32'h6000_1002);
    drain("split_drain");

    // Redirect to an odd halfword drops parcel 0 of the first word
    settle();
    lat = 1;
    mem[32'h6000_0100] = 32'h4505_0013;
    expect_i(32'h0000_4505, 32'h6000_0102, 1'b1);
    expect_i(32'h0000_0013, 32'h6000_0104, 1'b0);
    expect_i(32'h0000_0013, 32'h6000_0108, 1'b0);
    do_redirect(32'h6000_0102);
    drain("skip_drain");
    chk_log("skip_addr", 0, 32'h6000_0100);
`else
    // Without compressed support a 16-bit-looking word is still a 32-bit instruction
    settle();
    lat = 1;
    mem[32'h6000_5000] = 32'h0000_4501;
    expect_i(32'h0000_4501, 32'h6000_5000, 1'b0);
    expect_i(32'h0000_0013, 32'h6000_5004, 1'b0);
    do_redirect(32'h6000_5000);
    drain("norvc_drain");
    chk_log("norvc_addr", 0, 32'h6000_5000);
`endif

    // Reset mid-operation with a full buffer
    settle();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, o_valid}, 32'd0);
    chk("midrst_pc", o_pc, 32'h6000_0000);
    chk("midrst_addr", imem_addr, 32'h6000_0000);
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
